clk_div_prog: RTL and testbench

//  Multi-channel, run-time programmable clock divider. It is the successor to
//  the fixed power-of-two divider. Each channel produces a one-cycle tick
//  (a clock enable) and a 50%-duty square output. Ratios are arbitrary integers
//  and can be reprogrammed glitch-free while the channel runs.
//  It sits beside the CPU/bus, feeding the LED scan, the segment multiplexing
//  and the slow-step clock enables. No derived clocks are routed; consumers use

---
 rtl/clk_div_pkg.sv | 28 ++
 rtl/clk_div_chan.sv | 79 +++++++
 rtl/clk_div_prog.sv | 57 +++++
 tb/tb_clk_div_prog.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable multi-channel clock divider:
// default widths and divisor, channel-select width derivation and the
// board-level channel assignments.
package clk_div_pkg;

    localparam int          NCH_DEFAULT     = 4;
    localparam int          CW_DEFAULT      = 32;
    localparam logic [31:0] DEF_DIV_DEFAULT = 32'd255;

    // Fixed channel roles on the board.
    typedef enum int unsigned {
        CH_LED   = 0,
        CH_SEG   = 1,
        CH_STEP  = 2,
        CH_SPARE = 3
    } ch_idx_e;

    // Channel-select width: ceil(log2(n)), never less than one bit.
    function automatic int chw_f(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: up-counter compared against the active divisor, a
// shadow divisor that is promoted only at the wrap, a registered one-cycle
// tick and a square output that toggles on every tick.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int            CW      = CW_DEFAULT,
    parameter logic [CW-1:0] DEF_DIV = CW'(DEF_DIV_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          sync_clr_i,
    input  logic          wr_i,
    input  logic [CW-1:0] wr_div_i,
    output logic          tick_o,
    output logic          sq_o,
    output logic [CW-1:0] act_div_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] act_q, act_d;
    logic [CW-1:0] shd_q, shd_d;
    logic          tick_q, tick_d;
    logic          sq_q, sq_d;
    logic          term;

    // cnt only changes to 0 in the same cycle act can change, so == suffices.
    assign term = (cnt_q == act_q);

    // Next state: idle and clear override counting; a write always lands in
    // the shadow and reaches the active divisor only at a wrap or while idle.
    always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        shd_d  = wr_i ? wr_div_i : shd_q;
        if (!en_i) begin
            cnt_d = '0;
            sq_d  = 1'b0;
            if (wr_i) begin
                act_d = wr_div_i;
            end
        end else if (sync_clr_i) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (term) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
            act_d  = shd_d;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Channel state; async reset drops any partially counted period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            act_q  <= DEF_DIV;
            shd_q  <= DEF_DIV;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick_o    = tick_q;
    assign sq_o      = sq_q;
    assign act_div_o = act_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel run-time programmable clock divider. Each channel produces a
// clock-enable tick and a 50% square output; consumers gate on clk with tick.
// Divisor writes are addressed by wr_ch, which also selects the read-back.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int            NCH     = NCH_DEFAULT,
    parameter int            CW      = CW_DEFAULT,
    parameter logic [CW-1:0] DEF_DIV = CW'(DEF_DIV_DEFAULT),
    parameter int            CHW     = chw_f(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] en,
    input  logic           sync_clr,
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [CW-1:0]  wr_div,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sq,
    output logic [CW-1:0]  rd_div
);

    logic [CW-1:0]  act_div [NCH];
    logic [NCH-1:0] wr_sel;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        // An out-of-range wr_ch matches no channel, so the write is dropped.
        assign wr_sel[i] = wr_en && (wr_ch == CHW'(i));

        clk_div_chan #(
            .CW      (CW),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .en_i       (en[i]),
            .sync_clr_i (sync_clr),
            .wr_i       (wr_sel[i]),
            .wr_div_i   (wr_div),
            .tick_o     (tick[i]),
            .sq_o       (sq[i]),
            .act_div_o  (act_div[i])
        );
    end

    // Read-back of the active divisor; unmapped channel numbers read as 0.
    always_comb begin
        rd_div = '0;
        for (int i = 0; i < NCH; i++) begin
            if (wr_ch == CHW'(i)) begin
                rd_div = act_div[i];
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: a cycle model pushes expected tick/sq vectors into a
// queue, a negedge monitor pops and compares; directed scenarios add
// hand-computed tick spacing, output and read-back checks.
module tb_clk_div_prog;
    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int CHW = 3;
    localparam logic [CW-1:0] DEF = 32'd255;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] en;
    logic           sync_clr;
    logic           wr_en;
    logic [CHW-1:0] wr_ch;
    logic [CW-1:0]  wr_div;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;
    logic [CW-1:0]  rd_div;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    clk_div_prog #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF), .CHW(CHW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (sync_clr),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_div   (wr_div),
        .tick     (tick),
        .sq       (sq),
        .rd_div   (rd_div)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: counts down the cycles left in the current period.
    logic [CW-1:0]      m_act [NCH];
    logic [CW-1:0]      m_shd [NCH];
    logic [CW-1:0]      m_left[NCH];
    logic [NCH-1:0]     m_sq;
    logic [2*NCH-1:0]   exp_q[$];

    always @(posedge clk or negedge rst_n) begin : model
        logic [NCH-1:0] nt, ns;
        logic [CW-1:0]  na, nsh, nl;
        logic           wr;
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_act[c]  <= DEF;
                m_shd[c]  <= DEF;
                m_left[c] <= DEF;
            end
            m_sq <= '0;
            exp_q.delete();
        end else begin
            nt = '0;
            ns = '0;
            for (int c = 0; c < NCH; c++) begin
                wr    = wr_en && (int'(wr_ch) == c);
                na    = m_act[c];
                nsh   = wr ? wr_div : m_shd[c];
                ns[c] = m_sq[c];
                if (!en[c] || sync_clr) begin
                    ns[c] = 1'b0;
                    if (wr && !en[c]) na = wr_div;
                    nl = na;
                end else if (m_left[c] == '0) begin
                    nt[c] = 1'b1;
                    ns[c] = ~m_sq[c];
                    na    = nsh;
                    nl    = na;
                end else begin
                    nl = m_left[c] - 32'd1;
                end
                m_act[c]  <= na;
                m_shd[c]  <= nsh;
                m_left[c] <= nl;
            end
            m_sq <= ns;
            exp_q.push_back({nt, ns});
        end
    end

    // Monitor: one expected entry per clock while out of reset.
    always @(negedge clk) begin : monitor
        logic [2*NCH-1:0] e;
        logic [CW-1:0]    erd;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("sb_tick@%0d", cyc), 64'(tick), 64'(e[2*NCH-1:NCH]));
            chk($sformatf("sb_sq@%0d", cyc), 64'(sq), 64'(e[NCH-1:0]));
            erd = (int'(wr_ch) < NCH) ? m_act[wr_ch[1:0]] : '0;
            chk($sformatf("sb_rd@%0d", cyc), 64'(rd_div), 64'(erd));
        end
    end

    task automatic await_tick(input int ch, input string name, output int at);
        at = -1;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            if (tick[ch]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL %s: no tick within 400 cycles", name);
        end
    endtask

    task automatic write_div(input int ch, input logic [CW-1:0] d);
        wr_en  = 1'b1;
        wr_ch  = CHW'(ch);
        wr_div = d;
        @(posedge clk); #1;
        wr_en  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, t, tp;
        int r;
        int ebit;
        logic [CW-1:0] exp_rd [NCH];
        rst_n = 1'b0; en = '0; sync_clr = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_tick", 64'(tick), 64'(0));
        chk("rst_sq", 64'(sq), 64'(0));
        chk("rst_rd", 64'(rd_div), 64'(255));

        // 1: reset mid-count, then default period from release
        en = 4'b0001;
        repeat (100) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t1_async_tick", 64'(tick), 64'(0));
        chk("t1_async_sq", 64'(sq), 64'(0));
        chk("t1_async_rd", 64'(rd_div), 64'(255));
        @(posedge clk); #1;
        rst_n = 1'b1;
        c0 = cyc;
        await_tick(0, "t1_first", t);
        chk("t1_first_gap", 64'(t - c0), 64'(256));
        chk("t1_sq_hi", 64'(sq[0]), 64'(1));
        tp = t;
        await_tick(0, "t1_second", t);
        chk("t1_second_gap", 64'(t - tp), 64'(256));
        chk("t1_sq_lo", 64'(sq[0]), 64'(0));

        // 2: reprogram a running channel mid-period
        write_div(1, 32'd9);
        chk("t2_idle_load", 64'(rd_div), 64'(9));
        en[1] = 1'b1;
        c0 = cyc;
        repeat (3) @(posedge clk);
        #1 write_div(1, 32'd4);
        chk("t2_rd_before_wrap", 64'(rd_div), 64'(9));
        await_tick(1, "t2_first", t);
        chk("t2_first_gap", 64'(t - c0), 64'(10));
        chk("t2_rd_after_wrap", 64'(rd_div), 64'(4));
        tp = t;
        await_tick(1, "t2_second", t);
        chk("t2_second_gap", 64'(t - tp), 64'(5));
        tp = t;
        await_tick(1, "t2_third", t);
        chk("t2_third_gap", 64'(t - tp), 64'(5));
        chk("t2_sq", 64'(sq[1]), 64'(1));

        // 3: D=0 runs at full rate; write at a terminal count bypasses
        write_div(2, 32'd0);
        en[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("t3_tick_%0d", k), 64'(tick[2]), 64'(1));
            chk($sformatf("t3_sq_%0d", k), 64'(sq[2]), 64'(k % 2));
        end
        write_div(2, 32'd2);
        c0 = cyc;
        await_tick(2, "t3_bypass", t);
        chk("t3_bypass_gap", 64'(t - c0), 64'(3));

        // 4: disable mid-period, re-enable restarts from phase 0
        write_div(3, 32'd15);
        en[3] = 1'b1;
        c0 = cyc;
        await_tick(3, "t4_first", t);
        chk("t4_first_gap", 64'(t - c0), 64'(16));
        repeat (7) @(posedge clk);
        #1 en[3] = 1'b0;
        @(posedge clk); #1;
        chk("t4_off_tick", 64'(tick[3]), 64'(0));
        chk("t4_off_sq", 64'(sq[3]), 64'(0));
        repeat (5) @(posedge clk);
        #1 en[3] = 1'b1;
        c0 = cyc;
        await_tick(3, "t4_restart", t);
        chk("t4_restart_gap", 64'(t - c0), 64'(16));

        // 5: sync_clr on the terminal-count cycle of ch0
        wr_ch = 3'd0;
        await_tick(0, "t5_sync", t);
        repeat (255) @(posedge clk);
        #1 sync_clr = 1'b1;
        @(posedge clk); #1;
        sync_clr = 1'b0;
        chk("t5_tick", 64'(tick), 64'(0));
        chk("t5_sq", 64'(sq), 64'(0));
        chk("t5_rd", 64'(rd_div), 64'(255));
        c0 = cyc;
        await_tick(0, "t5_after", t);
        chk("t5_after_gap", 64'(t - c0), 64'(256));

        // 6: out-of-range channel write is ignored
        write_div(7, 32'd3);
        chk("t6_rd_oob", 64'(rd_div), 64'(0));
        exp_rd[0] = 32'd255; exp_rd[1] = 32'd4; exp_rd[2] = 32'd2; exp_rd[3] = 32'd15;
        for (int c = 0; c < NCH; c++) begin
            @(posedge clk); #1;
            wr_ch = CHW'(c);
            #1 chk($sformatf("t6_rd_ch%0d", c), 64'(rd_div), 64'(exp_rd[c]));
        end

        // Random soak against the model
        en = '1;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            wr_en    = 1'b0;
            sync_clr = 1'b0;
            r = int'($urandom_range(0, 99));
            wr_ch = CHW'($urandom_range(0, 7));
            if (r < 12) begin
                wr_en  = 1'b1;
                wr_div = CW'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 49) == 0) begin
                ebit = int'($urandom_range(0, NCH - 1));
                en[ebit] = ~en[ebit];
            end
            if ($urandom_range(0, 299) == 0) sync_clr = 1'b1;
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        sync_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
